// File: rtl/rf_writeback_if.sv
// Handshake, write-port and forwarding signals between the ALU/LSU producers,
// the register-file writeback front end, and the register file.
interface rf_writeback_if #(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int DATA_WIDTH          = 32
);
  localparam int AW = $clog2(NUMBER_OF_REGISTERS);

  logic                  alu_valid_i;
  logic                  alu_ready_o;
  logic [AW-1:0]         alu_rd_address_i;
  logic [DATA_WIDTH-1:0] alu_data_i;
  logic                  lsu_valid_i;
  logic                  lsu_ready_o;
  logic [AW-1:0]         lsu_rd_address_i;
  logic [DATA_WIDTH-1:0] lsu_data_i;
  logic                  rd_we_o;
  logic [AW-1:0]         rd_address_o;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  busy_o;
  logic [AW-1:0]         rs1_address_i;
  logic [AW-1:0]         rs2_address_i;
  logic                  fwd_rs1_hit_o;
  logic                  fwd_rs2_hit_o;
  logic [DATA_WIDTH-1:0] fwd_rs1_data_o;
  logic [DATA_WIDTH-1:0] fwd_rs2_data_o;

  modport master (
    output alu_valid_i, alu_rd_address_i, alu_data_i,
    output lsu_valid_i, lsu_rd_address_i, lsu_data_i,
    output rs1_address_i, rs2_address_i,
    input  alu_ready_o, lsu_ready_o, rd_we_o, rd_address_o, rd_data_o, busy_o,
    input  fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_rs1_data_o, fwd_rs2_data_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_address_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_address_i, lsu_data_i,
    input  rs1_address_i, rs2_address_i,
    output alu_ready_o, lsu_ready_o, rd_we_o, rd_address_o, rd_data_o, busy_o,
    output fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_rs1_data_o, fwd_rs2_data_o
  );
endinterface

// File: rtl/rf_writeback.sv
// Register-file writeback front end: merges ALU/LSU results in order, drops x0, one write/cycle.
// Optional forwarding lookup of pending writes enabled by RF_WRITEBACK_FORWARD_EN.
module rf_writeback #(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int FIFO_DEPTH          = 4
) (
  input logic          clk,
  input logic          rst,
  rf_writeback_if.slave bus
);
  localparam int AW = $clog2(NUMBER_OF_REGISTERS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]         fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count, count_next, free;

  logic                  alu_wr, lsu_wr, pop, bypass;
  logic [1:0]            push_cnt;
  logic [AW-1:0]         push0_addr, push1_addr, byp_addr;
  logic [DATA_WIDTH-1:0] push0_data, push1_data, byp_data;

  // free is based on the registered count; a same-cycle pop does not help
  assign free            = CW'(FIFO_DEPTH) - count;
  assign bus.alu_ready_o = (free >= CW'(1));
  assign bus.lsu_ready_o = bus.alu_valid_i ? (free >= CW'(2)) : (free >= CW'(1));

  assign alu_wr = bus.alu_valid_i && bus.alu_ready_o && (bus.alu_rd_address_i != '0);
  assign lsu_wr = bus.lsu_valid_i && bus.lsu_ready_o && (bus.lsu_rd_address_i != '0);
  assign pop    = (count != '0);

  always_comb begin
    push_cnt   = 2'd0;
    bypass     = 1'b0;
    push0_addr = bus.alu_rd_address_i;
    push0_data = bus.alu_data_i;
    push1_addr = bus.lsu_rd_address_i;
    push1_data = bus.lsu_data_i;
    byp_addr   = bus.alu_rd_address_i;
    byp_data   = bus.alu_data_i;
    if (pop) begin
      push_cnt = 2'(alu_wr) + 2'(lsu_wr);
      if (!alu_wr && lsu_wr) begin
        push0_addr = bus.lsu_rd_address_i;
        push0_data = bus.lsu_data_i;
      end
    end else if (alu_wr) begin
      // ALU goes straight to the output stage; a concurrent LSU result queues
      bypass   = 1'b1;
      push_cnt = 2'(lsu_wr);
      push0_addr = bus.lsu_rd_address_i;
      push0_data = bus.lsu_data_i;
    end else if (lsu_wr) begin
      bypass   = 1'b1;
      byp_addr = bus.lsu_rd_address_i;
      byp_data = bus.lsu_data_i;
    end
    count_next = count + CW'(push_cnt) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) begin
      fifo_addr[wr_ptr] <= push0_addr;
      fifo_data[wr_ptr] <= push0_data;
    end
    if (push_cnt == 2'd2) begin
      fifo_addr[wr_ptr + PW'(1)] <= push1_addr;
      fifo_data[wr_ptr + PW'(1)] <= push1_data;
    end
  end

  // output stage: registered write port toward the register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count            <= '0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      bus.rd_we_o      <= 1'b0;
      bus.rd_address_o <= '0;
      bus.rd_data_o    <= '0;
      bus.busy_o       <= 1'b0;
    end else begin
      count       <= count_next;
      rd_ptr      <= rd_ptr + PW'(pop);
      wr_ptr      <= wr_ptr + PW'(push_cnt);
      bus.rd_we_o <= pop || bypass;
      bus.busy_o  <= (count_next != '0) || pop || bypass;
      if (pop) begin
        bus.rd_address_o <= fifo_addr[rd_ptr];
        bus.rd_data_o    <= fifo_data[rd_ptr];
      end else if (bypass) begin
        bus.rd_address_o <= byp_addr;
        bus.rd_data_o    <= byp_data;
      end
    end
  end

`ifdef RF_WRITEBACK_FORWARD_EN
  // scan oldest to youngest so the last match (youngest) wins
  function automatic logic [DATA_WIDTH:0] lookup(input logic [AW-1:0] rs);
    logic [DATA_WIDTH:0] res;
    logic [PW-1:0]       idx;
    res = '0;
    if (rs != '0) begin
      if (bus.rd_we_o && (bus.rd_address_o == rs))
        res = {1'b1, bus.rd_data_o};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if ((CW'(i) < count) && (fifo_addr[idx] == rs))
          res = {1'b1, fifo_data[idx]};
      end
    end
    return res;
  endfunction

  assign {bus.fwd_rs1_hit_o, bus.fwd_rs1_data_o} = lookup(bus.rs1_address_i);
  assign {bus.fwd_rs2_hit_o, bus.fwd_rs2_data_o} = lookup(bus.rs2_address_i);
`else
  assign bus.fwd_rs1_hit_o  = 1'b0;
  assign bus.fwd_rs2_hit_o  = 1'b0;
  assign bus.fwd_rs1_data_o = '0;
  assign bus.fwd_rs2_data_o = '0;
`endif
endmodule

// File: tb/tb_rf_writeback.sv
// Scoreboard bench for rf_writeback: expected writes queued on acceptance, checked on rd_we_o.
module tb_rf_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_writeback_if #(.NUMBER_OF_REGISTERS(32), .DATA_WIDTH(32)) bus ();
  rf_writeback #(.NUMBER_OF_REGISTERS(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int mcount = 0;
  logic m_we = 1'b0, m_busy = 1'b0;
  logic last_acc_a, last_acc_l;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rd_we_o) begin
      wr_t e;
      n_wr++;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", 64'(bus.rd_address_o), 64'(e.a));
        check("wr_data", 64'(bus.rd_data_o), 64'(e.d));
      end
    end
  end

  // one clock: check registered state, drive a request pair, predict acceptance
  task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    int mfree, n;
    logic er_a, er_l, acc_a, acc_l, pop;
    @(posedge clk); #1;
    check("rd_we", 64'(bus.rd_we_o), 64'(m_we));
    check("busy", 64'(bus.busy_o), 64'(m_busy));
    bus.alu_valid_i = av; bus.alu_rd_address_i = aa; bus.alu_data_i = ad;
    bus.lsu_valid_i = lv; bus.lsu_rd_address_i = la; bus.lsu_data_i = ld;
    #1;
    mfree = 4 - mcount;
    er_a  = (mfree >= 1);
    er_l  = av ? (mfree >= 2) : (mfree >= 1);
    check("alu_ready", 64'(bus.alu_ready_o), 64'(er_a));
    check("lsu_ready", 64'(bus.lsu_ready_o), 64'(er_l));
    acc_a = av && er_a;
    acc_l = lv && er_l;
    n = 0;
    if (acc_a && aa != 5'd0) begin sb.push_back('{a: aa, d: ad}); n++; end
    if (acc_l && la != 5'd0) begin sb.push_back('{a: la, d: ld}); n++; end
    pop = (mcount != 0);
    if (pop) mcount = mcount - 1 + n;
    else     mcount = (n > 0) ? n - 1 : 0;
    m_we   = pop || (n > 0);
    m_busy = (mcount != 0) || m_we;
    last_acc_a = acc_a;
    last_acc_l = acc_l;
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ia, il, guard, wr0;
    bus.alu_valid_i = 0; bus.alu_rd_address_i = 0; bus.alu_data_i = 0;
    bus.lsu_valid_i = 0; bus.lsu_rd_address_i = 0; bus.lsu_data_i = 0;
    bus.rs1_address_i = 0; bus.rs2_address_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 64'(bus.rd_we_o), 64'd0);
    check("rst_addr", 64'(bus.rd_address_o), 64'd0);
    check("rst_data", 64'(bus.rd_data_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_alu_ready", 64'(bus.alu_ready_o), 64'd1);
    check("rst_lsu_ready", 64'(bus.lsu_ready_o), 64'd1);
    @(negedge clk) rst = 1'b0;

    // single ALU write, then both producers at once, then a discarded x0 write
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    idle(1);
    check("t1_addr", 64'(bus.rd_address_o), 64'd5);
    check("t1_data", 64'(bus.rd_data_o), 64'hDEADBEEF);
    idle(2);
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    idle(3);
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
    idle(4);

    // back-to-back pairs with backpressure
    ia = 0; il = 0; guard = 0; wr0 = n_wr;
    while ((ia < 6 || il < 6) && guard < 40) begin
      cycle(ia < 6, 5'(ia + 1), 32'h100 + 32'(ia), il < 6, 5'(il + 10), 32'h200 + 32'(il));
      if (last_acc_a && ia < 6) ia++;
      if (last_acc_l && il < 6) il++;
      guard++;
    end
    check("stream_accepted", 64'(ia + il), 64'd12);
    idle(8);
    check("stream_writes", 64'(n_wr - wr0), 64'd12);

    // async reset with pending entries
    cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
    cycle(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4);
    cycle(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hA6);
    idle(1);
    #2 rst = 1'b1;
    #1;
    check("arst_we", 64'(bus.rd_we_o), 64'd0);
    check("arst_busy", 64'(bus.busy_o), 64'd0);
    check("arst_alu_ready", 64'(bus.alu_ready_o), 64'd1);
    sb.delete();
    mcount = 0; m_we = 1'b0; m_busy = 1'b0;
    @(negedge clk) rst = 1'b0;
    wr0 = n_wr;
    idle(4);
    check("arst_no_stale", 64'(n_wr - wr0), 64'd0);

    // forwarding: two pending writes to x7, youngest wins; x0 never hits
    bus.rs1_address_i = 5'd7; bus.rs2_address_i = 5'd0;
    cycle(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    idle(1);
`ifdef RF_WRITEBACK_FORWARD_EN
    check("fwd_rs1_hit", 64'(bus.fwd_rs1_hit_o), 64'd1);
    check("fwd_rs1_data", 64'(bus.fwd_rs1_data_o), 64'hB);
`else
    check("fwd_rs1_hit", 64'(bus.fwd_rs1_hit_o), 64'd0);
    check("fwd_rs1_data", 64'(bus.fwd_rs1_data_o), 64'd0);
`endif
    check("fwd_rs2_hit", 64'(bus.fwd_rs2_hit_o), 64'd0);
    idle(4);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
